// File: rtl/ret_addr_stack_if.sv
// Bundle of control-unit <-> return-address-stack signals.
// The control unit drives requests (master); the stack answers (slave).
interface ret_addr_stack_if #(
    parameter int DATA_W = 32,
    parameter int PTR_W  = 3
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              flush;
    logic              clr_err;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic [DATA_W-1:0] top;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;
    logic              ovf_err;
    logic              unf_err;

    modport master (
        output push, pop, push_data, flush, clr_err,
        input  pop_data, pop_valid, top, count, empty, full, ovf_err, unf_err
    );

    modport slave (
        input  push, pop, push_data, flush, clr_err,
        output pop_data, pop_valid, top, count, empty, full, ovf_err, unf_err
    );
endinterface

// File: rtl/ret_addr_stack_ctrl.sv
// Return-address stack for the multicycle CPU: push on JAL (StW), pop on
// stop-bit return (StR), with saturating pointer and sticky error flags.
module ret_addr_stack_ctrl #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int PTR_W  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    ret_addr_stack_if.slave bus
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              ovf_err_q, ovf_err_d;
    logic              unf_err_q, unf_err_d;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [1:0]        state;
    logic [PTR_W:0]    count_m1;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  free_idx;

    // State is decoded from the pointer; there is no separate state register.
    assign state    = (count_q == '0)      ? ST_EMPTY :
                      (count_q == DEPTH_C) ? ST_FULL  : ST_PARTIAL;
    assign count_m1 = count_q - 1'b1;
    assign top_idx  = count_m1[PTR_W-1:0];
    assign free_idx = count_q[PTR_W-1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_err_d   = bus.clr_err ? 1'b0 : ovf_err_q;
        unf_err_d   = bus.clr_err ? 1'b0 : unf_err_q;
        mem_we      = 1'b0;
        mem_waddr   = top_idx;
        mem_wdata   = bus.push_data;

        if (bus.flush) begin
            count_d = '0;
        end else begin
            unique case ({bus.push, bus.pop})
                2'b11: begin
                    pop_valid_d = 1'b1;
                    if (state == ST_EMPTY) begin
                        pop_data_d = bus.push_data;
                    end else begin
                        // Replace-top: old top leaves, new address takes its slot.
                        pop_data_d = mem_q[top_idx];
                        mem_we     = 1'b1;
                    end
                end
                2'b10: begin
                    if (state == ST_FULL) begin
                        ovf_err_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = free_idx;
                        count_d   = count_q + 1'b1;
                    end
                end
                2'b01: begin
                    pop_valid_d = 1'b1;
                    if (state == ST_EMPTY) begin
                        pop_data_d = '0;
                        unf_err_d  = 1'b1;
                    end else begin
                        pop_data_d = mem_q[top_idx];
                        count_d    = count_m1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_err_q   <= 1'b0;
            unf_err_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_err_q   <= ovf_err_d;
            unf_err_q   <= unf_err_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries above the
    // pointer are never observed, so a reset would only cost a wide clear.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.pop_data  = pop_data_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.top       = (state == ST_EMPTY) ? '0 : mem_q[top_idx];
    assign bus.count     = count_q;
    assign bus.empty     = (state == ST_EMPTY);
    assign bus.full      = (state == ST_FULL);
    assign bus.ovf_err   = ovf_err_q;
    assign bus.unf_err   = unf_err_q;

endmodule
